// File: rtl/perf_event_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_pkg
// Brief    : Shared constants and helpers for the performance-event monitor.
// Revision : 1.0 - initial release
// ============================================================================
package perf_pkg;

    localparam int NUM_CNT = 6;

    localparam logic [2:0] ADDR_CYC   = 3'd0;
    localparam logic [2:0] ADDR_INST  = 3'd1;
    localparam logic [2:0] ADDR_BR    = 3'd2;
    localparam logic [2:0] ADDR_MISP  = 3'd3;
    localparam logic [2:0] ADDR_FLUSH = 3'd4;
    localparam logic [2:0] ADDR_STALL = 3'd5;
    localparam logic [2:0] ADDR_OVF   = 3'd6;
    localparam logic [2:0] ADDR_ID    = 3'd7;

    localparam logic [31:0] PERF_ID = 32'h5045_5246;

    // Number of valid issue slots; a zero instruction word marks an empty slot.
    function automatic logic [1:0] slot_count(input logic [31:0] instr_a,
                                              input logic [31:0] instr_b);
        return {1'b0, (instr_a != 32'd0)} + {1'b0, (instr_b != 32'd0)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/perf_event_monitor_counter.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter
// Brief    : One live event counter with sticky wrap flag and snapshot shadow.
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic [1:0]       inc,
    input  logic             snap,
    output logic [CNT_W-1:0] live,
    output logic [CNT_W-1:0] shadow,
    output logic             ovf,
    output logic             ovf_shadow
);

    logic [CNT_W-1:0] r_live_q;
    logic [CNT_W-1:0] w_live_d;
    logic [CNT_W-1:0] r_shadow_q;
    logic [CNT_W-1:0] w_shadow_d;
    logic             r_ovf_q;
    logic             w_ovf_d;
    logic             r_ovf_shadow_q;
    logic             w_ovf_shadow_d;
    logic [CNT_W:0]   w_sum;

    // The extra sum bit is the wrap indication, which also covers the +2 case.
    always_comb begin
        w_sum          = {1'b0, r_live_q} + {{(CNT_W-1){1'b0}}, inc};
        w_live_d       = w_sum[CNT_W-1:0];
        w_ovf_d        = r_ovf_q | w_sum[CNT_W];
        if (clear) begin
            w_live_d = '0;
            w_ovf_d  = 1'b0;
        end
        w_shadow_d     = snap ? r_live_q : r_shadow_q;
        w_ovf_shadow_d = snap ? r_ovf_q  : r_ovf_shadow_q;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_live_q       <= '0;
            r_shadow_q     <= '0;
            r_ovf_q        <= 1'b0;
            r_ovf_shadow_q <= 1'b0;
        end else begin
            r_live_q       <= w_live_d;
            r_shadow_q     <= w_shadow_d;
            r_ovf_q        <= w_ovf_d;
            r_ovf_shadow_q <= w_ovf_shadow_d;
        end
    end

    assign live       = r_live_q;
    assign shadow     = r_shadow_q;
    assign ovf        = r_ovf_q;
    assign ovf_shadow = r_ovf_shadow_q;

endmodule
`default_nettype wire

// File: rtl/perf_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : perf_event_monitor
// Brief    : Pipeline event counters with atomic snapshot and registered reads.
// Revision : 1.0 - initial release
// ============================================================================
module perf_event_monitor #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             count_en,
    input  logic             clear,
    input  logic             snapshot,
    input  logic [31:0]      instruction_0,
    input  logic [31:0]      instruction_1,
    input  logic             Branch_EX,
    input  logic             falseTaken,
    input  logic             falseNotTaken,
    input  logic             Flush,
    input  logic             hazard_detected,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data
);
    import perf_pkg::*;

    localparam logic [63:0] c_id_ext = {32'd0, PERF_ID};

    logic [1:0]         w_inc [NUM_CNT];
    logic [CNT_W-1:0]   w_live [NUM_CNT];
    logic [CNT_W-1:0]   w_shadow [NUM_CNT];
    logic [NUM_CNT-1:0] w_ovf;
    logic [NUM_CNT-1:0] w_ovf_shadow;
    logic [NUM_CNT-1:0] w_unused_live;
    logic [CNT_W-1:0]   w_id;
    logic [CNT_W-1:0]   w_ovf_ext;

    logic               r_rd_valid_q;
    logic               w_rd_valid_d;
    logic [CNT_W-1:0]   r_rd_data_q;
    logic [CNT_W-1:0]   w_rd_data_d;

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            w_inc[i] = 2'd0;
        end
        if (count_en) begin
            w_inc[ADDR_CYC]   = 2'd1;
            w_inc[ADDR_INST]  = slot_count(instruction_0, instruction_1);
            w_inc[ADDR_BR]    = {1'b0, Branch_EX};
            w_inc[ADDR_MISP]  = {1'b0, Branch_EX & (falseTaken | falseNotTaken)};
            w_inc[ADDR_FLUSH] = {1'b0, Flush};
            w_inc[ADDR_STALL] = {1'b0, hazard_detected};
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            perf_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk        (clk),
                .Reset      (Reset),
                .clear      (clear),
                .inc        (w_inc[gi]),
                .snap       (snapshot),
                .live       (w_live[gi]),
                .shadow     (w_shadow[gi]),
                .ovf        (w_ovf[gi]),
                .ovf_shadow (w_ovf_shadow[gi])
            );
            // Live values are only observable through the shadows.
            assign w_unused_live[gi] = (^w_live[gi]) ^ w_ovf[gi];
        end
    endgenerate

    assign w_id      = c_id_ext[CNT_W-1:0];
    assign w_ovf_ext = {{(CNT_W-NUM_CNT){1'b0}}, w_ovf_shadow};

    always_comb begin
        w_rd_valid_d = rd_en;
        w_rd_data_d  = r_rd_data_q;
        if (rd_en) begin
            case (rd_addr)
                ADDR_CYC:   w_rd_data_d = w_shadow[0];
                ADDR_INST:  w_rd_data_d = w_shadow[1];
                ADDR_BR:    w_rd_data_d = w_shadow[2];
                ADDR_MISP:  w_rd_data_d = w_shadow[3];
                ADDR_FLUSH: w_rd_data_d = w_shadow[4];
                ADDR_STALL: w_rd_data_d = w_shadow[5];
                ADDR_OVF:   w_rd_data_d = w_ovf_ext;
                default:    w_rd_data_d = w_id;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_rd_valid_q <= 1'b0;
            r_rd_data_q  <= '0;
        end else begin
            r_rd_valid_q <= w_rd_valid_d;
            r_rd_data_q  <= w_rd_data_d;
        end
    end

    assign rd_valid = r_rd_valid_q;
    assign rd_data  = r_rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_event_monitor
// Brief    : Directed and random checks of 64-bit and 8-bit monitors against
//            a since-clear event-total model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perf_event_monitor;

    localparam int NC = 6;

    logic        clk = 1'b0;
    logic        Reset, count_en, clear, snapshot;
    logic [31:0] instruction_0, instruction_1;
    logic        Branch_EX, falseTaken, falseNotTaken, Flush, hazard_detected;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic        rd_valid_w, rd_valid_n;
    logic [63:0] rd_data_w;
    logic [7:0]  rd_data_n;

    // Model: events counted since the last clear, and the copy taken at snapshot.
    longint unsigned tot [NC];
    longint unsigned sh  [NC];
    logic            exp_valid;
    logic [63:0]     exp_w, exp_n;
    int              total = 0;
    int              bad   = 0;

    always #5 clk = ~clk;

    perf_event_monitor #(.CNT_W(64)) u_dut_w (
        .clk(clk), .Reset(Reset), .count_en(count_en), .clear(clear),
        .snapshot(snapshot), .instruction_0(instruction_0),
        .instruction_1(instruction_1), .Branch_EX(Branch_EX),
        .falseTaken(falseTaken), .falseNotTaken(falseNotTaken), .Flush(Flush),
        .hazard_detected(hazard_detected), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid_w), .rd_data(rd_data_w)
    );

    perf_event_monitor #(.CNT_W(8)) u_dut_n (
        .clk(clk), .Reset(Reset), .count_en(count_en), .clear(clear),
        .snapshot(snapshot), .instruction_0(instruction_0),
        .instruction_1(instruction_1), .Branch_EX(Branch_EX),
        .falseTaken(falseTaken), .falseNotTaken(falseNotTaken), .Flush(Flush),
        .hazard_detected(hazard_detected), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid_n), .rd_data(rd_data_n)
    );

    function automatic logic [63:0] fold(input longint unsigned v, input int w);
        if (w >= 64) return v;
        return v % (64'd1 << w);
    endfunction

    function automatic logic [63:0] model_read(input logic [2:0] a, input int w);
        logic [63:0] r;
        r = '0;
        if (int'(a) < NC) begin
            r = fold(sh[int'(a)], w);
        end else if (a == 3'd6) begin
            for (int i = 0; i < NC; i++) r[i] = (w < 64) && (sh[i] >= (64'd1 << w));
        end else begin
            r = fold(64'h5045_5246, w);
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_instr();
        if ($urandom_range(0, 2) == 0) return 32'd0;
        return $urandom | 32'd1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        Reset = 1'b0; count_en = 1'b0; clear = 1'b0; snapshot = 1'b0;
        instruction_0 = 32'd0; instruction_1 = 32'd0;
        Branch_EX = 1'b0; falseTaken = 1'b0; falseNotTaken = 1'b0;
        Flush = 1'b0; hazard_detected = 1'b0; rd_en = 1'b0; rd_addr = 3'd0;
    endtask

    // One clock: predict from pre-edge model state, advance the model, compare.
    task automatic tick();
        if (Reset) begin
            exp_valid = 1'b0; exp_w = '0; exp_n = '0;
            for (int i = 0; i < NC; i++) begin tot[i] = 0; sh[i] = 0; end
        end else begin
            exp_valid = rd_en;
            if (rd_en) begin
                exp_w = model_read(rd_addr, 64);
                exp_n = model_read(rd_addr, 8);
            end
            if (snapshot) for (int i = 0; i < NC; i++) sh[i] = tot[i];
            if (clear) begin
                for (int i = 0; i < NC; i++) tot[i] = 0;
            end else if (count_en) begin
                tot[0] += 1;
                tot[1] += (instruction_0 != 0 ? 1 : 0) + (instruction_1 != 0 ? 1 : 0);
                tot[2] += Branch_EX ? 1 : 0;
                tot[3] += (Branch_EX && (falseTaken || falseNotTaken)) ? 1 : 0;
                tot[4] += Flush ? 1 : 0;
                tot[5] += hazard_detected ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
        check("rd_valid_w", {63'd0, rd_valid_w}, {63'd0, exp_valid});
        check("rd_valid_n", {63'd0, rd_valid_n}, {63'd0, exp_valid});
        check($sformatf("rd_data_w a=%0d", rd_addr), rd_data_w, exp_w);
        check($sformatf("rd_data_n a=%0d", rd_addr), {56'd0, rd_data_n}, exp_n);
    endtask

    task automatic read_expect(input logic [2:0] a, input logic [63:0] lit_w,
                               input logic [7:0] lit_n);
        set_idle();
        rd_en = 1'b1; rd_addr = a;
        tick();
        check($sformatf("plan_w a=%0d", a), rd_data_w, lit_w);
        check($sformatf("plan_n a=%0d", a), {56'd0, rd_data_n}, {56'd0, lit_n});
        set_idle();
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) begin
            set_idle();
            rd_en = 1'b1; rd_addr = 3'(a);
            tick();
        end
        set_idle();
        tick();
    endtask

    task automatic do_snapshot();
        set_idle();
        snapshot = 1'b1;
        tick();
        set_idle();
    endtask

    initial begin
        set_idle();
        Reset = 1'b1;
        tick();
        rd_en = 1'b1; rd_addr = 3'd7;
        tick();
        set_idle();

        for (int a = 0; a < 7; a++) read_expect(3'(a), 64'd0, 8'd0);
        read_expect(3'd7, 64'h5045_5246, 8'h46);
        tick();

        // 10 counting cycles: 7 dual-issue, 3 single-issue.
        for (int k = 0; k < 10; k++) begin
            set_idle();
            count_en = 1'b1;
            instruction_0 = $urandom | 32'd1;
            instruction_1 = (k < 7) ? ($urandom | 32'd1) : 32'd0;
            tick();
        end
        do_snapshot();
        read_expect(3'd0, 64'd10, 8'd10);
        read_expect(3'd1, 64'd17, 8'd17);

        for (int k = 0; k < 16; k++) begin
            set_idle();
            count_en = 1'b1;
            if (k < 5) begin
                Branch_EX = 1'b1;
                falseTaken = (k < 2);
                falseNotTaken = (k == 2);
            end else if (k == 5) begin
                falseTaken = 1'b1;
            end else if (k < 9) begin
                Flush = 1'b1;
            end else if (k < 13) begin
                hazard_detected = 1'b1;
            end
            tick();
        end
        do_snapshot();
        read_expect(3'd2, 64'd5, 8'd5);
        read_expect(3'd3, 64'd3, 8'd3);
        read_expect(3'd4, 64'd3, 8'd3);
        read_expect(3'd5, 64'd4, 8'd4);

        // Narrow-counter wrap: reach 254 instructions, then one dual-issue cycle.
        set_idle(); clear = 1'b1; tick();
        for (int k = 0; k < 255; k++) begin
            set_idle();
            count_en = 1'b1;
            instruction_0 = $urandom | 32'd1;
            instruction_1 = (k == 254) ? ($urandom | 32'd1) : 32'd0;
            tick();
        end
        do_snapshot();
        read_expect(3'd0, 64'd255, 8'd255);
        read_expect(3'd1, 64'd256, 8'd0);
        read_expect(3'd6, 64'd0, 8'h02);
        set_idle(); clear = 1'b1; tick();
        do_snapshot();
        read_expect(3'd6, 64'd0, 8'd0);

        // Snapshot, clear and an event on the same edge.
        for (int k = 0; k < 3; k++) begin
            set_idle(); count_en = 1'b1; Branch_EX = 1'b1; tick();
        end
        set_idle();
        snapshot = 1'b1; clear = 1'b1; count_en = 1'b1; Branch_EX = 1'b1;
        tick();
        read_expect(3'd2, 64'd3, 8'd3);
        for (int k = 0; k < 2; k++) begin
            set_idle(); count_en = 1'b1; Flush = 1'b1; tick();
        end
        do_snapshot();
        read_expect(3'd2, 64'd0, 8'd0);
        read_expect(3'd4, 64'd2, 8'd2);

        // Disabled counting window with every event asserted.
        do_snapshot();
        read_all();
        for (int k = 0; k < 20; k++) begin
            set_idle();
            instruction_0 = $urandom | 32'd1; instruction_1 = $urandom | 32'd1;
            Branch_EX = 1'b1; falseTaken = 1'b1; falseNotTaken = 1'b1;
            Flush = 1'b1; hazard_detected = 1'b1;
            tick();
        end
        do_snapshot();
        read_all();
        read_expect(3'd4, 64'd2, 8'd2);

        // Randomised traffic, including occasional reset and clear.
        for (int k = 0; k < 600; k++) begin
            Reset           = ($urandom_range(0, 199) == 0);
            count_en        = ($urandom_range(0, 3) != 0);
            clear           = ($urandom_range(0, 47) == 0);
            snapshot        = ($urandom_range(0, 5) == 0);
            instruction_0   = rnd_instr();
            instruction_1   = rnd_instr();
            Branch_EX       = $urandom_range(0, 1) == 1;
            falseTaken      = $urandom_range(0, 2) == 0;
            falseNotTaken   = $urandom_range(0, 2) == 0;
            Flush           = $urandom_range(0, 3) == 0;
            hazard_detected = $urandom_range(0, 2) == 0;
            rd_en           = $urandom_range(0, 1) == 1;
            rd_addr         = 3'($urandom_range(0, 7));
            tick();
        end
        set_idle();
        do_snapshot();
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
